// File: rtl/bist_march_ctrl_if.sv
// bist_march_ctrl_if -- memory-side bus between the March BIST controller and the RAM under test.
// master: the BIST controller drives address/controls/write data and receives read data.
// slave : the memory (or its model) receives controls and returns read data one cycle later.
interface bist_march_ctrl_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] BIST_ADDR;
    logic                  BIST_CE;
    logic                  BIST_CSB;
    logic                  BIST_WEB;
    logic                  BIST_OEB;
    logic [7:0]            BIST_IDATA;
    logic [7:0]            MEM_ODATA;

    modport master (
        output BIST_ADDR,
        output BIST_CE,
        output BIST_CSB,
        output BIST_WEB,
        output BIST_OEB,
        output BIST_IDATA,
        input  MEM_ODATA
    );

    modport slave (
        input  BIST_ADDR,
        input  BIST_CE,
        input  BIST_CSB,
        input  BIST_WEB,
        input  BIST_OEB,
        input  BIST_IDATA,
        output MEM_ODATA
    );
endinterface

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl -- March C- memory BIST sequencer with a block-level fault bitmap
// that raises one repair request per newly failing block, up to MAX_FAULT_BLOCK spares.
// Optional feature: define BIST_CHECKERBOARD_EN to append M6 (up w55) and
// M7 (up r55, wAA) after M5; without it M5 goes straight to DRAIN.
module bist_march_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int BLOCK_SIZE      = 128,
    parameter int MAX_FAULT_BLOCK = 25
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    bist_march_ctrl_if.master     mem,
    output logic                  BIST_EN,
    output logic                  BIST_PASS,
    output logic [ADDR_WIDTH-1:0] NEED_REPAIR_ADDR,
    output logic                  BIST_DONE,
    output logic                  BIST_FAIL
);
    localparam int         BLK_LSB = $clog2(BLOCK_SIZE);
    localparam int         BLK_W   = ADDR_WIDTH - BLK_LSB;
    localparam int         NBLK    = 2 ** BLK_W;
    localparam logic [4:0] MAX_CNT = 5'(MAX_FAULT_BLOCK);

`ifdef BIST_CHECKERBOARD_EN
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_M6, S_M7, S_DRAIN, S_DONE
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;
`endif

    // ---------------------------------------------------------------
    // March element table
    // ---------------------------------------------------------------
    function automatic logic is_access(input state_t s);
        case (s)
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: return 1'b1;
`ifdef BIST_CHECKERBOARD_EN
            S_M6, S_M7:                         return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_up(input state_t s);
        case (s)
            S_M3, S_M4: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic has_rd(input state_t s);
        case (s)
            S_M1, S_M2, S_M3, S_M4, S_M5: return 1'b1;
`ifdef BIST_CHECKERBOARD_EN
            S_M7:                         return 1'b1;
`endif
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic has_wr(input state_t s);
        case (s)
            S_M0, S_M1, S_M2, S_M3, S_M4: return 1'b1;
`ifdef BIST_CHECKERBOARD_EN
            S_M6, S_M7:                   return 1'b1;
`endif
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] rd_val(input state_t s);
        case (s)
            S_M2, S_M4: return 8'hFF;
`ifdef BIST_CHECKERBOARD_EN
            S_M7:       return 8'h55;
`endif
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] wr_val(input state_t s);
        case (s)
            S_M1, S_M3: return 8'hFF;
`ifdef BIST_CHECKERBOARD_EN
            S_M6:       return 8'h55;
            S_M7:       return 8'hAA;
`endif
            default:    return 8'h00;
        endcase
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            S_M0:    return S_M1;
            S_M1:    return S_M2;
            S_M2:    return S_M3;
            S_M3:    return S_M4;
            S_M4:    return S_M5;
`ifdef BIST_CHECKERBOARD_EN
            S_M5:    return S_M6;
            S_M6:    return S_M7;
`endif
            default: return S_DRAIN;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Sequencer state
    // ---------------------------------------------------------------
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    // Write-phase flag of a read+write element; in DRAIN it counts the two wait cycles.
    logic                  wph_q, wph_d;
    logic [7:0]            exp_q;
    logic                  start_acc;
    logic                  last_addr;
    logic                  acc_d, wr_d;

    // Next state: walk addresses within an element, hop straight into the next element at its end.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wph_d     = wph_q;
        start_acc = START && (state_q == S_IDLE || state_q == S_DONE);
        last_addr = is_up(state_q) ? (addr_q == '1) : (addr_q == '0);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d = S_M0;
                    addr_d  = '0;
                    wph_d   = 1'b0;
                end
            end
            S_DRAIN: begin
                if (wph_q) begin
                    state_d = S_DONE;
                    wph_d   = 1'b0;
                end else begin
                    wph_d = 1'b1;
                end
            end
            default: begin
                if (has_rd(state_q) && has_wr(state_q) && !wph_q) begin
                    wph_d = 1'b1;
                end else begin
                    wph_d = 1'b0;
                    if (last_addr) begin
                        state_d = next_elem(state_q);
                        addr_d  = is_up(state_d) ? '0 : '1;
                    end else begin
                        addr_d = is_up(state_q) ? addr_q + 1'b1 : addr_q - 1'b1;
                    end
                end
            end
        endcase
        acc_d = is_access(state_d);
        wr_d  = acc_d && has_wr(state_d) && (!has_rd(state_d) || wph_d);
    end

    // FSM register with memory controls and status levels registered from the next state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            wph_q          <= 1'b0;
            exp_q          <= '0;
            mem.BIST_CE    <= 1'b0;
            mem.BIST_CSB   <= 1'b1;
            mem.BIST_WEB   <= 1'b1;
            mem.BIST_OEB   <= 1'b1;
            mem.BIST_ADDR  <= '0;
            mem.BIST_IDATA <= '0;
            BIST_EN        <= 1'b0;
            BIST_DONE      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wph_q          <= wph_d;
            exp_q          <= rd_val(state_d);
            mem.BIST_CE    <= acc_d;
            mem.BIST_CSB   <= !acc_d;
            mem.BIST_WEB   <= !wr_d;
            mem.BIST_OEB   <= !(acc_d && !wr_d);
            mem.BIST_ADDR  <= acc_d ? addr_d : '0;
            mem.BIST_IDATA <= wr_d ? wr_val(state_d) : 8'h00;
            BIST_EN        <= (state_d != S_IDLE) && (state_d != S_DONE);
            BIST_DONE      <= (state_d == S_DONE);
        end
    end

    // ---------------------------------------------------------------
    // Read compare and fault bitmap
    // ---------------------------------------------------------------
    logic                  rd1_q;
    logic [7:0]            exp1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;
    logic [NBLK-1:0]       bmap_q;
    logic [4:0]            fcnt_q;
    logic [BLK_W-1:0]      blk;
    logic                  new_blk;

    assign blk     = addr1_q[ADDR_WIDTH-1:BLK_LSB];
    assign new_blk = rd1_q && (mem.MEM_ODATA != exp1_q) && !bmap_q[blk];

    // Track reads one cycle behind the bus, compare returned data and report first fault per block.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd1_q            <= 1'b0;
            exp1_q           <= '0;
            addr1_q          <= '0;
            bmap_q           <= '0;
            fcnt_q           <= '0;
            BIST_PASS        <= 1'b0;
            NEED_REPAIR_ADDR <= '0;
            BIST_FAIL        <= 1'b0;
        end else begin
            rd1_q     <= mem.BIST_CE && !mem.BIST_OEB;
            exp1_q    <= exp_q;
            addr1_q   <= mem.BIST_ADDR;
            BIST_PASS <= 1'b0;
            if (start_acc) begin
                bmap_q    <= '0;
                fcnt_q    <= '0;
                BIST_FAIL <= 1'b0;
            end else if (new_blk) begin
                bmap_q[blk] <= 1'b1;
                if (fcnt_q != 5'd31) begin
                    fcnt_q <= fcnt_q + 5'd1;
                end
                if (fcnt_q < MAX_CNT) begin
                    BIST_PASS        <= 1'b1;
                    NEED_REPAIR_ADDR <= addr1_q;
                end else begin
                    BIST_FAIL <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl -- scoreboard bench for bist_march_ctrl against a faulty-RAM model.
// Honours BIST_CHECKERBOARD_EN (adds M6/M7 to the reference and a 0x55-coupling scenario).
module tb_bist_march_ctrl;
    localparam int AW   = 9;
    localparam int N    = 1 << AW;
    localparam int BS   = 16;
    localparam int NBLK = N / BS;
    localparam int MAXF = 25;
`ifdef BIST_CHECKERBOARD_EN
    localparam int NELEM   = 8;
    localparam int RUN_CYC = 13 * N + 3;
`else
    localparam int NELEM   = 6;
    localparam int RUN_CYC = 10 * N + 3;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          en, pass, done, fail;
    logic [AW-1:0] need;

    bist_march_ctrl_if #(.ADDR_WIDTH(AW)) mif ();

    bist_march_ctrl #(
        .ADDR_WIDTH      (AW),
        .BLOCK_SIZE      (BS),
        .MAX_FAULT_BLOCK (MAXF)
    ) dut (
        .CLK              (clk),
        .RSTN             (rstn),
        .START            (start),
        .mem              (mif),
        .BIST_EN          (en),
        .BIST_PASS        (pass),
        .NEED_REPAIR_ADDR (need),
        .BIST_DONE        (done),
        .BIST_FAIL        (fail)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } acc_t;

    acc_t acc_q[$];
    int   rep_q[$];
    bit   exp_fail;

    logic [7:0] ram [N];
    logic [7:0] sa0 [N];
    logic [7:0] sa1 [N];
    bit         cpl [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Faulty read path: coupling fault flips bit0 only when the cell holds 0x55.
    function automatic logic [7:0] frd(input int a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (cpl[a] && v == 8'h55) r = v ^ 8'h01;
        return (r & ~sa0[a]) | sa1[a];
    endfunction

    // Synchronous RAM: read data appears the cycle after the read is presented.
    always @(posedge clk) begin
        if (mif.BIST_CE && !mif.BIST_CSB) begin
            if (!mif.BIST_WEB) ram[mif.BIST_ADDR] <= mif.BIST_IDATA;
            else if (!mif.BIST_OEB) mif.MEM_ODATA <= frd(int'(mif.BIST_ADDR), ram[mif.BIST_ADDR]);
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = 8'h00;
            sa1[i] = 8'h00;
            cpl[i] = 1'b0;
        end
    endtask

    task automatic elem(input int e, output bit up, output bit rd, output logic [7:0] rv,
                        output bit wr, output logic [7:0] wv);
        up = 1; rd = 0; wr = 0; rv = 8'h00; wv = 8'h00;
        case (e)
            0: begin wr = 1; wv = 8'h00; end
            1: begin rd = 1; rv = 8'h00; wr = 1; wv = 8'hFF; end
            2: begin rd = 1; rv = 8'hFF; wr = 1; wv = 8'h00; end
            3: begin up = 0; rd = 1; rv = 8'h00; wr = 1; wv = 8'hFF; end
            4: begin up = 0; rd = 1; rv = 8'hFF; wr = 1; wv = 8'h00; end
            5: begin rd = 1; rv = 8'h00; end
            6: begin wr = 1; wv = 8'h55; end
            7: begin rd = 1; rv = 8'h55; wr = 1; wv = 8'hAA; end
            default: ;
        endcase
    endtask

    // Reference: replay the March algorithm on an array, collect accesses and repair reports.
    task automatic build_model();
        logic [7:0] mm [N];
        bit         seen [NBLK];
        int         cnt;
        bit         up, rd, wr;
        logic [7:0] rv, wv, v;
        int         a;
        acc_q.delete();
        rep_q.delete();
        exp_fail = 0;
        cnt = 0;
        for (int i = 0; i < N; i++) mm[i] = 8'h00;
        for (int i = 0; i < NBLK; i++) seen[i] = 0;
        for (int e = 0; e < NELEM; e++) begin
            elem(e, up, rd, rv, wr, wv);
            for (int k = 0; k < N; k++) begin
                a = up ? k : N - 1 - k;
                if (rd) begin
                    acc_q.push_back('{we: 1'b0, addr: AW'(a), data: 8'h00});
                    v = frd(a, mm[a]);
                    if (v != rv && !seen[a / BS]) begin
                        seen[a / BS] = 1;
                        if (cnt < MAXF) rep_q.push_back(a);
                        else exp_fail = 1;
                        cnt++;
                    end
                end
                if (wr) begin
                    mm[a] = wv;
                    acc_q.push_back('{we: 1'b1, addr: AW'(a), data: wv});
                end
            end
        end
    endtask

    // Bus monitor: every enabled access must be the next one the reference expects.
    always @(negedge clk) begin
        acc_t        x;
        logic [31:0] act, expv;
        if (mif.BIST_CE === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("unexpected access", 32'd1, 32'd0);
            end else begin
                x    = acc_q.pop_front();
                act  = {12'h0, mif.BIST_CSB, mif.BIST_WEB, mif.BIST_OEB, mif.BIST_ADDR,
                        (x.we ? mif.BIST_IDATA : 8'h00)};
                expv = {12'h0, 1'b0, ~x.we, x.we, x.addr, x.data};
                chk("access csb/web/oeb/addr/data", act, expv);
            end
        end
    end

    // Repair monitor: each BIST_PASS pulse must match the next expected faulty address.
    always @(negedge clk) begin
        int r;
        if (pass === 1'b1) begin
            if (rep_q.size() == 0) begin
                chk("unexpected BIST_PASS", 32'd1, 32'd0);
            end else begin
                r = rep_q.pop_front();
                chk("NEED_REPAIR_ADDR", 32'(need), 32'(r));
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, " ce/csb/web/oeb"}, {28'h0, mif.BIST_CE, mif.BIST_CSB, mif.BIST_WEB, mif.BIST_OEB}, 32'h7);
        chk({name, " addr"}, 32'(mif.BIST_ADDR), 32'h0);
        chk({name, " idata"}, 32'(mif.BIST_IDATA), 32'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string name, input int mid_start);
        int cyc;
        build_model();
        pulse_start();
        cyc = 1;
        chk({name, " EN after START"}, 32'(en), 32'd1);
        chk({name, " DONE cleared"}, 32'(done), 32'd0);
        chk({name, " FAIL cleared"}, 32'(fail), 32'd0);
        while (done !== 1'b1 && cyc < RUN_CYC + 50) begin
            start = (cyc == mid_start);
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        chk({name, " cycles to DONE"}, 32'(cyc), 32'(RUN_CYC));
        chk({name, " DONE"}, 32'(done), 32'd1);
        chk({name, " EN after DONE"}, 32'(en), 32'd0);
        chk({name, " FAIL"}, 32'(fail), 32'(exp_fail));
        chk({name, " missing reports"}, 32'(rep_q.size()), 32'd0);
        chk({name, " missing accesses"}, 32'(acc_q.size()), 32'd0);
        chk_idle({name, " done bus"});
    endtask

    initial begin
        int blks [NBLK];
        int a, j, tmp, nf, cyc;
        rstn  = 1'b0;
        start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset EN", 32'(en), 32'd0);
        chk("reset PASS", 32'(pass), 32'd0);
        chk("reset DONE", 32'(done), 32'd0);
        chk("reset FAIL", 32'(fail), 32'd0);
        chk_idle("reset");
        @(negedge clk) rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post-reset quiet EN", 32'(en), 32'd0);
        chk("post-reset quiet DONE", 32'(done), 32'd0);

        run("clean", 0);

        clear_faults();
        sa0['h085] = 8'h08;
        run("sa0 bit3 0x085", 2 * N);

        clear_faults();
        sa1['h100] = 8'h01;
        sa1['h10F] = 8'h40;
        run("same block 0x100/0x10F", 0);

        clear_faults();
        for (int i = 0; i < NBLK; i++) blks[i] = i;
        for (int i = NBLK - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = blks[i]; blks[i] = blks[j]; blks[j] = tmp;
        end
        for (int i = 0; i < 26; i++) begin
            a = blks[i] * BS + $urandom_range(0, BS - 1);
            if ($urandom_range(0, 1) == 1) sa0[a] = 8'h01 << $urandom_range(0, 7);
            else sa1[a] = 8'h01 << $urandom_range(0, 7);
        end
        run("26 blocks", 0);

        clear_faults();
        build_model();
        pulse_start();
        cyc = 1;
        while (cyc < 3 * N + 37) begin
            @(posedge clk);
            #1 cyc++;
        end
        #2 rstn = 1'b0;
        #1;
        chk("abort EN", 32'(en), 32'd0);
        chk("abort PASS", 32'(pass), 32'd0);
        chk("abort DONE", 32'(done), 32'd0);
        chk("abort FAIL", 32'(fail), 32'd0);
        chk("abort NEED_REPAIR_ADDR", 32'(need), 32'd0);
        chk_idle("abort");
        acc_q.delete();
        rep_q.delete();
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort quiet EN", 32'(en), 32'd0);
        chk("abort quiet DONE", 32'(done), 32'd0);
        chk_idle("abort quiet");
        run("after abort", 0);

        for (int r = 0; r < 2; r++) begin
            clear_faults();
            nf = $urandom_range(1, 6);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 1) sa0[a] = 8'h01 << $urandom_range(0, 7);
                else sa1[a] = 8'h01 << $urandom_range(0, 7);
            end
            run("random", $urandom_range(2, RUN_CYC - 10));
        end

`ifdef BIST_CHECKERBOARD_EN
        clear_faults();
        cpl['h100] = 1'b1;
        run("coupling 0x100", 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
